// File: rtl/piano_defs_pkg.sv
// Shared piano definitions: mode codes decoded by the selector and players, song index width,
// and the mode FSM state encoding used by mode_ctrl.
package piano_defs_pkg;

  localparam int unsigned SongW = 2;

  localparam logic [2:0] MODE_IDLE   = 3'b000;
  localparam logic [2:0] MODE_AUTO   = 3'b011;
  localparam logic [2:0] MODE_MANUAL = 3'b001;
  localparam logic [2:0] MODE_LEARN  = 3'b111;

  typedef logic [SongW-1:0] song_t;

  typedef enum logic [1:0] {
    StIdle,
    StAuto,
    StManual,
    StLearn
  } mode_state_e;

  function automatic mode_state_e next_mode(input mode_state_e s);
    unique case (s)
      StIdle:   return StAuto;
      StAuto:   return StManual;
      StManual: return StLearn;
      default:  return StIdle;
    endcase
  endfunction

  function automatic logic [2:0] mode_code(input mode_state_e s);
    unique case (s)
      StIdle:   return MODE_IDLE;
      StAuto:   return MODE_AUTO;
      StManual: return MODE_MANUAL;
      default:  return MODE_LEARN;
    endcase
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// One push button: 2-flop synchroniser, stability counter, and a one-cycle press pulse
// on the debounced rising edge (release gives no pulse).
module btn_debounce #(
  parameter logic [19:0] DEBOUNCE_CYCLES = 20'd1_000_000
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic btn_i,
  output logic press_o
);

  logic        sync1_q, sync2_q;
  logic        level_q, level_d;
  logic        level_prev_q;
  logic        press_q;
  logic [19:0] cnt_q, cnt_d;

  always_comb begin
    level_d = level_q;
    cnt_d   = '0;
    if (sync2_q != level_q) begin
      if (cnt_q == DEBOUNCE_CYCLES - 20'd1) begin
        level_d = sync2_q;
      end else begin
        cnt_d = cnt_q + 20'd1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync1_q      <= 1'b0;
      sync2_q      <= 1'b0;
      level_q      <= 1'b0;
      level_prev_q <= 1'b0;
      press_q      <= 1'b0;
      cnt_q        <= '0;
    end else begin
      sync1_q      <= btn_i;
      sync2_q      <= sync1_q;
      level_q      <= level_d;
      level_prev_q <= level_q;
      // Registered edge detect puts the pulse DEBOUNCE_CYCLES+2 edges after first sampling.
      press_q      <= level_q & ~level_prev_q;
      cnt_q        <= cnt_d;
    end
  end

  assign press_o = press_q;

endmodule

// File: rtl/mode_ctrl.sv
// Piano front-end: debounced buttons drive the mode/song FSM and a one-cycle restart strobe.
// Optional inactivity timeout back to IDLE is enabled by defining IDLE_TIMEOUT_EN.
module mode_ctrl
  import piano_defs_pkg::*;
#(
  parameter logic [19:0] DEBOUNCE_CYCLES = 20'd1_000_000,
  parameter logic [2:0]  NUM_SONGS       = 3'd4,
  parameter logic [31:0] TIMEOUT_CYCLES  = 32'd1_000_000_000
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             btn_mode_i,
  input  logic             btn_next_i,
  input  logic             btn_prev_i,
  output logic [2:0]       mode_o,
  output logic [SongW-1:0] song_num_o,
  output logic             restart_o
);

  localparam song_t LastSong = song_t'(NUM_SONGS - 3'd1);

  logic        mode_p, next_p, prev_p, any_press;
  logic        timeout_hit;
  mode_state_e state_q, state_d;
  song_t       song_q, song_d;
  logic        restart_q, restart_d;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_mode (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .btn_i  (btn_mode_i),
    .press_o(mode_p)
  );

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_next (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .btn_i  (btn_next_i),
    .press_o(next_p)
  );

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_prev (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .btn_i  (btn_prev_i),
    .press_o(prev_p)
  );

  assign any_press = mode_p | next_p | prev_p;

`ifdef IDLE_TIMEOUT_EN
  logic [31:0] idle_cnt_q, idle_cnt_d;

  assign timeout_hit = (state_q != StIdle) && (idle_cnt_q == TIMEOUT_CYCLES - 32'd1);

  always_comb begin
    idle_cnt_d = idle_cnt_q + 32'd1;
    if (any_press || state_q == StIdle || timeout_hit) begin
      idle_cnt_d = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      idle_cnt_q <= '0;
    end else begin
      idle_cnt_q <= idle_cnt_d;
    end
  end
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT_CYCLES;
  assign timeout_hit    = 1'b0;
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= StIdle;
      song_q    <= '0;
      restart_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      song_q    <= song_d;
      restart_q <= restart_d;
    end
  end

  // Mode press outranks timeout and song steps; next+prev together cancel.
  always_comb begin
    state_d = state_q;
    song_d  = song_q;
    if (mode_p) begin
      state_d = next_mode(state_q);
    end else if (timeout_hit) begin
      state_d = StIdle;
    end else if (state_q == StAuto || state_q == StLearn) begin
      if (next_p && !prev_p) begin
        song_d = (song_q == LastSong) ? '0 : song_q + song_t'(1);
      end else if (prev_p && !next_p) begin
        song_d = (song_q == '0) ? LastSong : song_q - song_t'(1);
      end
    end
    restart_d = (state_d != state_q) || (song_d != song_q);
  end

  always_comb begin
    mode_o     = mode_code(state_q);
    song_num_o = song_q;
    restart_o  = restart_q;
  end

endmodule

// File: tb/tb_mode_ctrl.sv
// Scoreboard bench for mode_ctrl: stimulus pushes expected (mode, song) on each restart,
// a negedge monitor pops and compares whenever restart is seen.
module tb_mode_ctrl;
  import piano_defs_pkg::*;

  logic       clk = 1'b0;
  logic       rst_i;
  logic       btn_mode_i, btn_next_i, btn_prev_i;
  logic [2:0] mode_o;
  logic [1:0] song_num_o;
  logic       restart_o;

  typedef struct packed {
    logic [2:0] mode;
    logic [1:0] song;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_vec = 0;
  int   n_err = 0;
  int   edges;

  always #5 clk = ~clk;

  mode_ctrl #(
    .DEBOUNCE_CYCLES(20'd4),
    .NUM_SONGS      (3'd4),
    .TIMEOUT_CYCLES (32'd50)
  ) dut (
    .clk_i     (clk),
    .rst_i     (rst_i),
    .btn_mode_i(btn_mode_i),
    .btn_next_i(btn_next_i),
    .btn_prev_i(btn_prev_i),
    .mode_o    (mode_o),
    .song_num_o(song_num_o),
    .restart_o (restart_o)
  );

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic expect_out(input logic [2:0] m, input logic [1:0] s);
    sb.push_back('{mode: m, song: s});
  endtask

  task automatic press(input logic m, input logic n, input logic p, input int hold);
    @(negedge clk);
    btn_mode_i = m;
    btn_next_i = n;
    btn_prev_i = p;
    repeat (hold) @(negedge clk);
    btn_mode_i = 1'b0;
    btn_next_i = 1'b0;
    btn_prev_i = 1'b0;
    repeat (14) @(negedge clk);
  endtask

  // Monitor: every restart cycle must match the next queued expectation.
  always @(negedge clk) begin
    if (restart_o) begin
      if (sb.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_restart: got mode=%0d song=%0d, expected no restart",
                 mode_o, song_num_o);
      end else begin
        mon_e = sb.pop_front();
        check("restart_mode", int'(mode_o), int'(mon_e.mode));
        check("restart_song", int'(song_num_o), int'(mon_e.song));
      end
    end
  end

  initial begin
    // 1: reset with all buttons high
    rst_i      = 1'b1;
    btn_mode_i = 1'b1;
    btn_next_i = 1'b1;
    btn_prev_i = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_mode", int'(mode_o), int'(MODE_IDLE));
    check("reset_song", int'(song_num_o), 0);
    check("reset_restart", int'(restart_o), 0);
    rst_i      = 1'b0;
    btn_mode_i = 1'b0;
    btn_next_i = 1'b0;
    btn_prev_i = 1'b0;
    repeat (15) @(negedge clk);
    check("post_reset_mode", int'(mode_o), int'(MODE_IDLE));

    // 2: press latency, mode appears on the 8th edge after the raise
    expect_out(MODE_AUTO, 2'd0);
    @(negedge clk);
    btn_mode_i = 1'b1;
    edges = 0;
    while (!restart_o && edges < 30) begin
      @(posedge clk);
      #1;
      edges++;
    end
    check("press_latency_edges", edges, 8);
    check("latency_mode", int'(mode_o), int'(MODE_AUTO));
    repeat (2) @(negedge clk);
    btn_mode_i = 1'b0;
    repeat (14) @(negedge clk);
    check("sb_drained_auto", sb.size(), 0);

    // 3: glitch ignored, next wraps, prev wraps
    press(1'b0, 1'b1, 1'b0, 3);
    check("glitch_song", int'(song_num_o), 0);
    for (int i = 1; i <= 5; i++) begin
      expect_out(MODE_AUTO, 2'(i % 4));
      press(1'b0, 1'b1, 1'b0, 10);
    end
    check("next_x5_song", int'(song_num_o), 1);
    expect_out(MODE_AUTO, 2'd0);
    press(1'b0, 1'b0, 1'b1, 10);
    expect_out(MODE_AUTO, 2'd3);
    press(1'b0, 1'b0, 1'b1, 10);
    check("prev_wrap_song", int'(song_num_o), 3);
    press(1'b0, 1'b1, 1'b1, 10);
    check("next_prev_cancel", int'(song_num_o), 3);
    check("sb_drained_songs", sb.size(), 0);

    // 4: MANUAL ignores next; mode wins over simultaneous next
    expect_out(MODE_MANUAL, 2'd3);
    press(1'b1, 1'b0, 1'b0, 10);
    press(1'b0, 1'b1, 1'b0, 10);
    check("manual_next_song", int'(song_num_o), 3);
    check("manual_mode", int'(mode_o), int'(MODE_MANUAL));
    expect_out(MODE_LEARN, 2'd3);
    press(1'b1, 1'b0, 1'b0, 10);
    expect_out(MODE_IDLE, 2'd3);
    press(1'b1, 1'b0, 1'b0, 10);
    expect_out(MODE_AUTO, 2'd3);
    press(1'b1, 1'b0, 1'b0, 10);
    expect_out(MODE_AUTO, 2'd2);
    press(1'b0, 1'b0, 1'b1, 10);
    expect_out(MODE_MANUAL, 2'd2);
    press(1'b1, 1'b1, 1'b0, 10);
    check("mode_wins_mode", int'(mode_o), int'(MODE_MANUAL));
    check("mode_wins_song", int'(song_num_o), 2);

    // 5: full mode cycle, then reset mid-debounce
    expect_out(MODE_LEARN, 2'd2);
    press(1'b1, 1'b0, 1'b0, 10);
    expect_out(MODE_IDLE, 2'd2);
    press(1'b1, 1'b0, 1'b0, 10);
    expect_out(MODE_AUTO, 2'd2);
    press(1'b1, 1'b0, 1'b0, 10);
    check("cycle_auto", int'(mode_o), int'(MODE_AUTO));
    expect_out(MODE_MANUAL, 2'd2);
    press(1'b1, 1'b0, 1'b0, 10);
    check("cycle_manual", int'(mode_o), int'(MODE_MANUAL));
    expect_out(MODE_LEARN, 2'd2);
    press(1'b1, 1'b0, 1'b0, 10);
    check("cycle_learn", int'(mode_o), int'(MODE_LEARN));
    expect_out(MODE_IDLE, 2'd2);
    press(1'b1, 1'b0, 1'b0, 10);
    check("cycle_idle", int'(mode_o), int'(MODE_IDLE));
    check("sb_drained_cycle", sb.size(), 0);
    @(negedge clk);
    btn_mode_i = 1'b1;
    repeat (4) @(negedge clk);
    rst_i      = 1'b1;
    btn_mode_i = 1'b0;
    @(negedge clk);
    check("mid_reset_restart", int'(restart_o), 0);
    rst_i = 1'b0;
    repeat (15) @(negedge clk);
    check("mid_reset_mode", int'(mode_o), int'(MODE_IDLE));
    check("mid_reset_song", int'(song_num_o), 0);

    // 6: inactivity in LEARN
    expect_out(MODE_AUTO, 2'd0);
    press(1'b1, 1'b0, 1'b0, 10);
    expect_out(MODE_MANUAL, 2'd0);
    press(1'b1, 1'b0, 1'b0, 10);
    expect_out(MODE_LEARN, 2'd0);
    press(1'b1, 1'b0, 1'b0, 10);
`ifdef IDLE_TIMEOUT_EN
    expect_out(MODE_IDLE, 2'd0);
    repeat (60) @(negedge clk);
    check("timeout_mode", int'(mode_o), int'(MODE_IDLE));
`else
    repeat (200) @(negedge clk);
    check("no_timeout_mode", int'(mode_o), int'(MODE_LEARN));
`endif
    check("sb_drained_final", sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
